// File: rtl/blinker_pkg.sv
// rtl/blinker_pkg.sv - shared constants and debounce FSM state type for the LED blinker
// Contents:
//   DEFAULT_CLK_FREQ : system clock frequency in Hz, shared with the blinker
//   state_t          : 2-bit debounce FSM state encoding
package blinker_pkg;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_ARM_HIGH = 2'd1,
        S_HIGH     = 2'd2,
        S_ARM_LOW  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for one asynchronous bit
// Ports:
//   clk   : destination clock, rising edge
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d_i   : asynchronous input bit
//   q_o   : synchronised copy of d_i, two clk edges later
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/button_debounce_toggle.sv
// rtl/button_debounce_toggle.sv - push-button synchroniser, debouncer and blink enable toggle
// Ports:
//   clk           : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   btn_raw       : raw, bouncy, asynchronous button (active high)
//   clear_en      : synchronous request to force blink_en low
//   btn_level     : debounced button level
//   press_pulse   : one-cycle pulse on each debounced 0->1
//   release_pulse : one-cycle pulse on each debounced 1->0
//   blink_en      : toggles on each press_pulse, gates the blinker
module button_debounce_toggle
    import blinker_pkg::*;
#(
    parameter int CLK_FREQ    = DEFAULT_CLK_FREQ,
    parameter int DEBOUNCE_MS = 20,
    parameter int CNT_W       = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic clear_en,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic blink_en
);

    localparam int DEBOUNCE_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;

    if (DEBOUNCE_CYCLES < 1 ||
        longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_cfg
        $error("button_debounce_toggle: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    // Terminal count: the ARM state has seen s2 hold for DEBOUNCE_CYCLES edges.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_sync;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             blink_q, blink_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_raw),
        .q_o   (btn_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            blink_q   <= blink_d;
        end
    end

    // Counter is cleared on every state change, so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOW: begin
                if (btn_sync) begin
                    state_d = S_ARM_HIGH;
                    cnt_d   = '0;
                end
            end
            S_ARM_HIGH: begin
                if (!btn_sync) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!btn_sync) begin
                    state_d = S_ARM_LOW;
                    cnt_d   = '0;
                end
            end
            S_ARM_LOW: begin
                if (btn_sync) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Pulses fire on qualification expiry only; clear_en has priority over a toggle.
    always_comb begin
        press_d   = (state_q == S_ARM_HIGH) && btn_sync  && (cnt_q == LAST_CNT);
        release_d = (state_q == S_ARM_LOW)  && !btn_sync && (cnt_q == LAST_CNT);
        level_d   = level_q;
        if (press_d) begin
            level_d = 1'b1;
        end else if (release_d) begin
            level_d = 1'b0;
        end
        blink_d = blink_q;
        if (clear_en) begin
            blink_d = 1'b0;
        end else if (press_d) begin
            blink_d = ~blink_q;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign blink_en      = blink_q;

endmodule

// File: tb/tb_button_debounce_toggle.sv
// tb/tb_button_debounce_toggle.sv - self-checking bench for button_debounce_toggle
module tb_button_debounce_toggle;

    localparam int D = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_raw;
    logic clear_en;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic blink_en;

    int checks = 0;
    int errors = 0;

    button_debounce_toggle #(
        .CLK_FREQ    (1000),
        .DEBOUNCE_MS (5),
        .CNT_W       (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .clear_en      (clear_en),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .blink_en      (blink_en)
    );

    always #5 clk = ~clk;

    // Reference model: the button is seen two edges late, and the level
    // flips once the delayed input has disagreed with it for D+1 edges in a row.
    bit m_seen_prev, m_seen_prev2;
    bit m_level, m_press, m_release, m_blink;
    int m_run;

    task automatic model_clear();
        m_seen_prev = 0; m_seen_prev2 = 0;
        m_level = 0; m_press = 0; m_release = 0; m_blink = 0; m_run = 0;
    endtask

    task automatic model_edge(input bit raw, input bit clr);
        bit x;
        x = m_seen_prev2;
        m_seen_prev2 = m_seen_prev;
        m_seen_prev = raw;
        m_press = 0;
        m_release = 0;
        if (x != m_level) m_run++;
        else m_run = 0;
        if (m_run == D + 1) begin
            m_level = x;
            m_run = 0;
            m_press = x;
            m_release = !x;
        end
        if (clr) m_blink = 0;
        else if (m_press) m_blink = !m_blink;
    endtask

    task automatic set_reset(input bit v);
        rst_n = v;
        if (!v) model_clear();
    endtask

    // Inputs change 1 time unit after an edge; outputs are read 1 unit after the next edge.
    task automatic step(input bit raw, input bit clr);
        btn_raw = raw;
        clear_en = clr;
        @(posedge clk);
        if (rst_n) model_edge(raw, clr);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input bit l, input bit p, input bit r, input bit b);
        check({name, ".btn_level"}, btn_level, l);
        check({name, ".press_pulse"}, press_pulse, p);
        check({name, ".release_pulse"}, release_pulse, r);
        check({name, ".blink_en"}, blink_en, b);
    endtask

    task automatic hold(input bit raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0);
    endtask

    typedef struct {
        bit raw;
        bit clr;
        bit level;
        bit press;
        bit release_p;
        bit blink;
    } vec_t;

    vec_t tbl[24];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt_p;
        int cnt_r;
        bit rv;
        int len;

        // Clean press (sampled at row 0), release (sampled at row 12), clear alone.
        tbl[0]  = '{1,0, 0,0,0,0};  tbl[1]  = '{1,0, 0,0,0,0};
        tbl[2]  = '{1,0, 0,0,0,0};  tbl[3]  = '{1,0, 0,0,0,0};
        tbl[4]  = '{1,0, 0,0,0,0};  tbl[5]  = '{1,0, 0,0,0,0};
        tbl[6]  = '{1,0, 0,0,0,0};  tbl[7]  = '{1,0, 1,1,0,1};
        tbl[8]  = '{1,0, 1,0,0,1};  tbl[9]  = '{1,0, 1,0,0,1};
        tbl[10] = '{1,0, 1,0,0,1};  tbl[11] = '{1,0, 1,0,0,1};
        tbl[12] = '{0,0, 1,0,0,1};  tbl[13] = '{0,0, 1,0,0,1};
        tbl[14] = '{0,0, 1,0,0,1};  tbl[15] = '{0,0, 1,0,0,1};
        tbl[16] = '{0,0, 1,0,0,1};  tbl[17] = '{0,0, 1,0,0,1};
        tbl[18] = '{0,0, 1,0,0,1};  tbl[19] = '{0,0, 0,0,1,1};
        tbl[20] = '{0,0, 0,0,0,1};  tbl[21] = '{0,0, 0,0,0,1};
        tbl[22] = '{0,1, 0,0,0,0};  tbl[23] = '{0,0, 0,0,0,0};

        btn_raw = 0;
        clear_en = 0;
        set_reset(0);

        // Reset with a toggling button: everything stays 0.
        for (int i = 0; i < 6; i++) begin
            step(i[0], 1'b0);
            check_outs("reset", 0, 0, 0, 0);
        end
        set_reset(1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            check_outs("post_reset", 0, 0, 0, 0);
        end

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].raw, tbl[i].clr);
            check_outs($sformatf("tbl[%0d]", i), tbl[i].level, tbl[i].press, tbl[i].release_p, tbl[i].blink);
        end

        // Bounce: high 3, low 1, then high; one press 7 edges after the last rise.
        cnt_r = 0;
        for (int k = 0; k < 20; k++) begin
            step((k == 3) ? 1'b0 : 1'b1, 1'b0);
            check($sformatf("bounce.press[%0d]", k), press_pulse, (k == 11));
            cnt_r += int'(release_pulse);
        end
        check("bounce.no_release", (cnt_r == 0), 1'b1);
        check_outs("bounce.end", 1, 0, 0, 1);

        // Release keeps blink_en; second press toggles it back to 0.
        cnt_r = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0);
            cnt_r += int'(release_pulse);
        end
        check("release.one_pulse", (cnt_r == 1), 1'b1);
        check_outs("release.end", 0, 0, 0, 1);
        cnt_p = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0);
            cnt_p += int'(press_pulse);
        end
        check("press2.one_pulse", (cnt_p == 1), 1'b1);
        check_outs("press2.end", 1, 0, 0, 0);

        // clear_en on the expiry edge while blink_en=0: clear wins.
        hold(1'b0, 10);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, (k == 7));
            if (k == 7) check_outs("clr_expiry", 1, 1, 0, 0);
        end
        check_outs("clr_expiry.end", 1, 0, 0, 0);

        // clear_en alone while blink_en=1.
        hold(1'b0, 10);
        hold(1'b1, 10);
        check_outs("clr_alone.pre", 1, 0, 0, 1);
        step(1'b1, 1'b1);
        check_outs("clr_alone", 1, 0, 0, 0);

        // Async reset mid-count with blink_en=1 beforehand.
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 10);
        hold(1'b1, 6);
        check_outs("arst.pre", 0, 0, 0, 1);
        set_reset(0);
        #1;
        check_outs("arst.immediate", 0, 0, 0, 0);
        #2;
        hold(1'b1, 2);
        check_outs("arst.held", 0, 0, 0, 0);
        set_reset(1);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0);
            check($sformatf("arst.press[%0d]", k), press_pulse, (k == 7));
            check($sformatf("arst.level[%0d]", k), btn_level, (k >= 7));
        end

        // Randomised bursts against the model.
        rv = 0;
        len = 0;
        for (int c = 0; c < 3000; c++) begin
            if (len == 0) begin
                rv = !rv;
                len = $urandom_range(1, 9);
            end
            len--;
            step(rv, ($urandom_range(0, 15) == 0));
            check("rnd.btn_level", btn_level, m_level);
            check("rnd.press_pulse", press_pulse, m_press);
            check("rnd.release_pulse", release_pulse, m_release);
            check("rnd.blink_en", blink_en, m_blink);
            check("rnd.exclusive", press_pulse & release_pulse, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
